// File: rtl/mem_calc_m.sv
`default_nettype none
// ============================================================================
//  Module      : mem_calc_m
//  Description : Two-stage load/store unit with a private byte-addressed
//                data memory; computes op1+imm and returns extended loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_calc_m #(
    parameter int WIDTH_REG = 7,
    parameter int WIDTH_BRM = 6,
    parameter int WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 18,
    parameter int DEPTH     = 256
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH-1:0]     i_instr,
    output logic [31:0]          o_data,
    output logic [WIDTH_REG-1:0] o_addr,
    output logic                 o_valid
);

    localparam int c_IDX_W     = $clog2(DEPTH);
    localparam int c_RD_LSB    = 64;
    localparam int c_IMM_LSB   = c_RD_LSB + WIDTH_REG;
    localparam int c_PC_LSB    = c_IMM_LSB + 32;
    localparam int c_UOP_LSB   = c_PC_LSB + 32;
    localparam int c_BRM_LSB   = c_UOP_LSB + 7;
    localparam int c_FUNC_LSB  = c_BRM_LSB + WIDTH_BRM;
    localparam int c_VALID_BIT = c_FUNC_LSB + 10;

    localparam logic [6:0] c_UOP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_UOP_STORE = 7'b0100011;

    // Stage-1 (address generation) registers
    logic [31:0]          r_ea_q,     w_ea_d;
    logic [31:0]          r_sdata_q,  w_sdata_d;
    logic [2:0]           r_funct3_q, w_funct3_d;
    logic [WIDTH_REG-1:0] r_rd_q,     w_rd_d;
    logic                 r_load_q,   w_load_d;
    logic                 r_store_q,  w_store_d;

    // Stage-2 (memory access) output registers
    logic [31:0]          r_data_q,   w_data_d;
    logic [WIDTH_REG-1:0] r_addr_q,   w_addr_d;
    logic                 r_valid_q,  w_valid_d;

    logic [31:0]          r_mem_q [DEPTH];

    logic [c_IDX_W-1:0]   w_idx;
    logic [31:0]          w_rword;
    logic [7:0]           w_rbyte;
    logic [15:0]          w_rhalf;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic                 w_we;
    logic                 w_unused;

    always_comb begin
        w_ea_d     = i_instr[31:0] + i_instr[c_IMM_LSB +: 32];
        w_sdata_d  = i_instr[63:32];
        w_funct3_d = i_instr[c_FUNC_LSB +: 3];
        w_rd_d     = i_instr[c_RD_LSB +: WIDTH_REG];
        w_load_d   = i_instr[c_VALID_BIT] && (i_instr[c_UOP_LSB +: 7] == c_UOP_LOAD);
        w_store_d  = i_instr[c_VALID_BIT] && (i_instr[c_UOP_LSB +: 7] == c_UOP_STORE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_load_q  <= 1'b0;
            r_store_q <= 1'b0;
        end else begin
            r_load_q  <= w_load_d;
            r_store_q <= w_store_d;
        end
        r_ea_q     <= w_ea_d;
        r_sdata_q  <= w_sdata_d;
        r_funct3_q <= w_funct3_d;
        r_rd_q     <= w_rd_d;
    end

    // Upper address bits are dropped, so accesses wrap around the memory
    assign w_idx   = r_ea_q[c_IDX_W+1:2];
    assign w_rword = r_mem_q[w_idx];
    assign w_rbyte = w_rword[{r_ea_q[1:0], 3'b000} +: 8];
    assign w_rhalf = r_ea_q[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_sdata_q;
        case (r_funct3_q)
            3'b000: begin
                w_be    = 4'b0001 << r_ea_q[1:0];
                w_wdata = {4{r_sdata_q[7:0]}};
            end
            3'b001: begin
                w_be    = r_ea_q[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_sdata_q[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // A reset edge cancels the store that would otherwise land on it
    assign w_we = r_store_q && !i_rst;

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem_q[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        w_data_d  = r_data_q;
        w_addr_d  = r_addr_q;
        w_valid_d = 1'b0;
        if (r_load_q) begin
            w_valid_d = 1'b1;
            w_addr_d  = r_rd_q;
            case (r_funct3_q)
                3'b000:  w_data_d = {{24{w_rbyte[7]}}, w_rbyte};
                3'b001:  w_data_d = {{16{w_rhalf[15]}}, w_rhalf};
                3'b010:  w_data_d = w_rword;
                3'b100:  w_data_d = {24'd0, w_rbyte};
                3'b101:  w_data_d = {16'd0, w_rhalf};
                default: w_data_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data_q  <= 32'd0;
            r_addr_q  <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_data_q  <= w_data_d;
            r_addr_q  <= w_addr_d;
            r_valid_q <= w_valid_d;
        end
    end

    assign o_data  = r_data_q;
    assign o_addr  = r_addr_q;
    assign o_valid = r_valid_q;

    // pc, branch mask, func[9:3] and high address bits carry no meaning here
    assign w_unused = ^{i_instr[c_PC_LSB +: 32], i_instr[c_BRM_LSB +: WIDTH_BRM],
                        i_instr[c_FUNC_LSB+3 +: 7], r_ea_q[31:c_IDX_W+2]};

endmodule
`default_nettype wire

// File: tb/tb_mem_calc_m.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_calc_m
//  Description : Self-checking bench for mem_calc_m against a byte-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_calc_m;

    localparam int WREG  = 7;
    localparam int WBRM  = 6;
    localparam int W     = 4*32 + WREG + WBRM + 18;
    localparam int DEPTH = 256;
    localparam int NBYTE = 4*DEPTH;

    localparam logic [6:0] c_LD = 7'b0000011;
    localparam logic [6:0] c_ST = 7'b0100011;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] ea;
        logic [31:0] sd;
        logic [6:0]  rd;
    } op_t;

    logic            clk;
    logic            i_rst;
    logic [W-1:0]    i_instr;
    logic [31:0]     o_data;
    logic [WREG-1:0] o_addr;
    logic            o_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mdl [NBYTE];
    op_t         pend;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [31:0] exp_addr;

    mem_calc_m #(.WIDTH_REG(WREG), .WIDTH_BRM(WBRM), .WIDTH(W), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_instr (i_instr),
        .o_data  (o_data),
        .o_addr  (o_addr),
        .o_valid (o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input op_t p);
        int unsigned a;
        logic [7:0]  b;
        logic [15:0] h;
        a = p.ea % NBYTE;
        b = mdl[a];
        h = {mdl[(a & ~32'd1) + 1], mdl[a & ~32'd1]};
        case (p.f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return {mdl[(a & ~32'd3) + 3], mdl[(a & ~32'd3) + 2],
                             mdl[(a & ~32'd3) + 1], mdl[a & ~32'd3]};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input op_t p);
        int unsigned a;
        a = p.ea % NBYTE;
        case (p.f3)
            3'b000: mdl[a] = p.sd[7:0];
            3'b001: for (int i = 0; i < 2; i++) mdl[(a & ~32'd1) + i] = p.sd[8*i +: 8];
            3'b010: for (int i = 0; i < 4; i++) mdl[(a & ~32'd3) + i] = p.sd[8*i +: 8];
            default: ;
        endcase
    endtask

    // Drives one bundle for one cycle; the op issued the cycle before
    // resolves at this edge, so its effect is checked right after it.
    task automatic issue(input logic rst, input logic vld, input logic [6:0] uop,
                         input logic [2:0] f3, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] imm, input logic [6:0] rd);
        logic [W-1:0] b;
        op_t nxt;
        b = '0;
        b[31:0]        = op1;
        b[63:32]       = op2;
        b[64 +: WREG]  = rd;
        b[71 +: 32]    = imm;
        b[103 +: 32]   = $urandom;
        b[135 +: 7]    = uop;
        b[142 +: WBRM] = WBRM'($urandom);
        b[148 +: 10]   = {7'($urandom), f3};
        b[W-1]         = vld;
        nxt.ld = vld && (uop == c_LD);
        nxt.st = vld && (uop == c_ST);
        nxt.f3 = f3;
        nxt.ea = op1 + imm;
        nxt.sd = op2;
        nxt.rd = rd;
        i_rst   = rst;
        i_instr = b;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_valid = 1'b0;
            exp_data  = 32'd0;
            exp_addr  = 32'd0;
            nxt.ld    = 1'b0;
            nxt.st    = 1'b0;
        end else begin
            exp_valid = 1'b0;
            if (pend.st) model_store(pend);
            if (pend.ld) begin
                exp_valid = 1'b1;
                exp_data  = model_load(pend);
                exp_addr  = {25'd0, pend.rd};
            end
        end
        pend = nxt;
        check_val("o_valid", {31'd0, o_valid}, {31'd0, exp_valid});
        check_val("o_data",  o_data, exp_data);
        check_val("o_addr",  {25'd0, o_addr}, exp_addr);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] ea, input logic [31:0] d);
        issue(1'b0, 1'b1, c_ST, f3, ea, d, 32'd0, 7'($urandom));
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] op1, input logic [31:0] imm,
                      input logic [6:0] rd);
        issue(1'b0, 1'b1, c_LD, f3, op1, 32'($urandom), imm, rd);
    endtask

    task automatic bub();
        issue(1'b0, 1'b0, c_ST, 3'b010, 32'd0, 32'hFFFF_FFFF, 32'd0, 7'd0);
    endtask

    initial begin
        pend.ld = 1'b0;
        pend.st = 1'b0;
        exp_valid = 1'b0;
        exp_data  = 32'd0;
        exp_addr  = 32'd0;
        for (int i = 0; i < NBYTE; i++) mdl[i] = 8'd0;

        issue(1'b1, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 7'd0);
        issue(1'b1, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 7'd0);
        check_val("reset_valid", {31'd0, o_valid}, 32'd0);
        check_val("reset_data", o_data, 32'd0);

        // Clear the whole memory so the model and DUT start equal
        for (int i = 0; i < DEPTH; i++) st(3'b010, 32'(4*i), 32'd0);

        issue(1'b0, 1'b1, c_ST, 3'b010, 32'd1, 32'd3, 32'd1, 7'd0);
        ld(3'b010, 32'd1, 32'd1, 7'd3);
        bub();
        check_val("sw_lw_data", o_data, 32'd3);
        check_val("sw_lw_addr", {25'd0, o_addr}, 32'd3);
        bub();
        check_val("lw_one_cycle", {31'd0, o_valid}, 32'd0);

        issue(1'b0, 1'b1, 7'd0, 3'b010, 32'd2, 32'd4, 32'd3, 7'd5);
        issue(1'b0, 1'b0, c_ST, 3'b010, 32'd2, 32'd4, 32'd3, 7'd5);
        ld(3'b010, 32'd0, 32'd0, 7'd9);
        bub();
        check_val("bubble_keeps_word0", o_data, 32'd3);

        st(3'b010, 32'd8, 32'h80F0_7F81);
        ld(3'b000, 32'd8, 32'd0, 7'd1);
        ld(3'b100, 32'd4, 32'd4, 7'd2);
        check_val("lb", o_data, 32'hFFFF_FF81);
        ld(3'b001, 32'd10, 32'd0, 7'd3);
        check_val("lbu", o_data, 32'h0000_0081);
        ld(3'b101, 32'd11, 32'hFFFF_FFFF, 7'd4);
        check_val("lh", o_data, 32'hFFFF_80F0);
        bub();
        check_val("lhu", o_data, 32'h0000_80F0);

        st(3'b010, 32'd16, 32'd0);
        st(3'b000, 32'd17, 32'h0000_00AB);
        st(3'b001, 32'd18, 32'h0000_1234);
        ld(3'b010, 32'd16, 32'd0, 7'd6);
        bub();
        check_val("partial_store", o_data, 32'h1234_AB00);

        st(3'b010, 32'd0, 32'h1111_1111);
        st(3'b010, 32'(4*DEPTH), 32'h2222_2222);
        ld(3'b010, 32'd0, 32'd0, 7'd7);
        ld(3'b010, 32'd8, 32'd0, 7'd8);
        check_val("wrap_data", o_data, 32'h2222_2222);
        bub();
        check_val("stream_valid", {31'd0, o_valid}, 32'd1);

        ld(3'b011, 32'd8, 32'd0, 7'd10);
        st(3'b011, 32'd8, 32'hDEAD_BEEF);
        check_val("bad_f3_load", o_data, 32'd0);
        ld(3'b010, 32'd8, 32'd0, 7'd11);
        bub();
        check_val("bad_f3_store", o_data, 32'h80F0_7F81);

        st(3'b010, 32'd20, 32'hCAFE_F00D);
        issue(1'b1, 1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 7'd0);
        ld(3'b010, 32'd20, 32'd0, 7'd12);
        bub();
        check_val("reset_drops_store", o_data, 32'd0);

        for (int n = 0; n < 600; n++) begin
            int unsigned sel;
            logic [6:0]  uop;
            sel = $urandom_range(0, 19);
            uop = (sel < 8) ? c_LD : (sel < 16) ? c_ST : 7'($urandom);
            issue(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), uop,
                  3'($urandom), 32'($urandom_range(0, 2*NBYTE)), $urandom,
                  (sel[0] ? 32'($urandom) : 32'($urandom_range(0, 15))), 7'($urandom));
        end
        bub();
        bub();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_calc_m.md
Name: mem_calc_m

Overview:
Load/store execution unit of the out-of-order RISC-V backend, fed by the memory issue queue with one packed micro-op bundle per cycle. It computes the effective address (op1 + imm) and accesses a private byte-addressed data memory. For loads, it returns the extended result, tagged with the physical destination register, to the writeback/bypass network.

Parameters:
WIDTH_REG, 7, physical register tag width.
WIDTH_BRM, 6, branch mask width.
WIDTH, 4*32+WIDTH_REG+WIDTH_BRM+18 (=159 with defaults), total i_instr width; must equal that formula.
DEPTH, 256, data memory size in 32-bit words; power of two.

Ports:
i_clk  input  1  clock; all state updates on the rising edge.
i_rst  input  1  synchronous, active-high reset.
i_instr  input  WIDTH  packed bundle, LSB first: op1[31:0], op2[31:0], rd[WIDTH_REG], imm[31:0], pc[31:0], uop[6:0], brmask[WIDTH_BRM], func[9:0], valid (MSB).
o_data  output  32  load result.
o_addr  output  WIDTH_REG  destination register tag of the load result.
o_valid  output  1  o_data/o_addr valid this cycle (loads only).

Behaviour:
- Reset (i_rst=1 at an edge): o_data=0, o_addr=0, o_valid=0, stage-1 valid cleared. Memory contents are not reset; simulation initialises memory to all zeros.
- Decode: load when uop==7'b0000011; store when uop==7'b0100011; any other uop, or valid=0, is a bubble with no memory or output effect. func[2:0] is funct3; func[9:3], pc and brmask are ignored.
- Stage 1 (edge N): register ea=op1+imm (mod 2^32), store data=op2, funct3, rd, is_load, is_store, valid.
- Stage 2 (edge N+1):
  - Store: write memory at edge N+1.
  - Load: combinational read; o_data/o_addr/o_valid registered at edge N+1.
  - Latency: a bundle presented before edge N produces output visible after edge N+1. Throughput is 1 per cycle.
- Memory: little-endian, word index = ea[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap.
- Store widths (funct3):
  - 000 SB: byte lane ea[1:0] = op2[7:0].
  - 001 SH: lanes {ea[1],0} and {ea[1],1} = op2[15:0]; ea[0] ignored.
  - 010 SW: whole word = op2; ea[1:0] ignored.
  - Other funct3 values: no write.
- Load widths (funct3):
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - Other funct3 values: o_valid=1, o_data=0.
  - Alignment is handled as for stores: low address bits are dropped.
- Output after a store or bubble: o_valid=0. o_data and o_addr hold their previous values.
- Store then load back-to-back: the load reads memory one edge after the store wrote it, so the new data is returned. No forwarding path is needed.
- No flush or kill input; a valid bundle always completes.
- Reset asserted mid-operation: an in-flight stage-1 op is dropped and no store is performed at that edge.

Test Plan:
- Reset: hold i_rst=1 for 2 edges -> o_valid=0, o_data=0, o_addr=0.
- SW then LW: SW with op1=1, imm=1, op2=3. Then LW (func=010) with op1=1, imm=1, rd=3 -> 2 edges after LW: o_data=3, o_addr=3, o_valid=1, for exactly one cycle if followed by a bubble.
- Bubble: uop=0 with op1=2, imm=3, op2=4, then valid=0 -> o_valid=0 on both outputs; memory word 0 still reads 3 on a later LW.
- Byte/half extension: SW 0x80F0_7F81 at ea=8.
  - LB ea=8 -> 0xFFFFFF81; LBU ea=8 -> 0x00000081.
  - LH ea=10 -> 0xFFFF80F0; LHU ea=10 -> 0x000080F0.
- Partial store: SW 0 at ea=16, then SB op2=0xAB at ea=17, then SH op2=0x1234 at ea=18 -> LW ea=16 returns 0x1234AB00.
- Streaming/wrap: back-to-back SW at ea=0 and at ea=4*DEPTH with different data, then LW ea=0 -> second value, o_valid asserted every load cycle.
